// File: rtl/hcsr04_trig_ctrl_if.sv
// rtl/hcsr04_trig_ctrl_if.sv - shot request, echo measurement and result signals of the ranging initiator
interface hcsr04_trig_ctrl_if;
  logic        start;
  logic        auto_en;
  logic        echo;
  logic        echo_done;
  logic [19:0] du;
  logic        trig;
  logic        busy;
  logic        meas_valid;
  logic [19:0] meas_du;
  logic        timeout;

  modport master (
    output start, auto_en, echo, echo_done, du,
    input  trig, busy, meas_valid, meas_du, timeout
  );

  modport slave (
    input  start, auto_en, echo, echo_done, du,
    output trig, busy, meas_valid, meas_du, timeout
  );
endinterface

// File: rtl/hcsr04_trig_ctrl.sv
// rtl/hcsr04_trig_ctrl.sv - HC-SR04 initiator: trigger pulse, echo rise/width timeouts, holdoff, one result per shot
module hcsr04_trig_ctrl #(
  parameter int unsigned TRIG_CYCLES      = 1000,
  parameter int unsigned ECHO_WAIT_CYCLES = 2500000,
  parameter int unsigned ECHO_MAX_CYCLES  = 4000000,
  parameter int unsigned HOLDOFF_CYCLES   = 6000000,
  parameter int unsigned CNT_W            = 24
) (
  input  logic              clk,
  input  logic              rst,
  hcsr04_trig_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_WAIT_DONE,
    S_HOLDOFF
  } state_e;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ECHO_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(ECHO_MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             echo_meta_q, echo_s_q;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic [19:0]      meas_du_q, meas_du_d;

  logic done_hit;
  logic to_hit;

  // echo_done takes priority over a width timeout landing on the same cycle
  assign done_hit = (state_q == S_WAIT_DONE) && bus.echo_done;
  assign to_hit   = ((state_q == S_WAIT_RISE) && !echo_s_q && (cnt_q == WAIT_LAST)) ||
                    ((state_q == S_WAIT_DONE) && !bus.echo_done && (cnt_q == MAX_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      echo_meta_q  <= 1'b0;
      echo_s_q     <= 1'b0;
      trig_q       <= 1'b0;
      busy_q       <= 1'b0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      meas_du_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      echo_meta_q  <= bus.echo;
      echo_s_q     <= echo_meta_q;
      trig_q       <= trig_d;
      busy_q       <= busy_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
      meas_du_q    <= meas_du_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (bus.start || bus.auto_en) state_d = S_TRIG;
      S_TRIG:      if (cnt_q == TRIG_LAST) state_d = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (echo_s_q)    state_d = S_WAIT_DONE;
        else if (to_hit) state_d = S_HOLDOFF;
      end
      S_WAIT_DONE: if (done_hit || to_hit) state_d = S_HOLDOFF;
      S_HOLDOFF:   if (cnt_q == HOLD_LAST) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    // Counter restarts on every state entry; saturation is only a guard, the exits bound it
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q == '1)   cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    trig_d       = (state_d == S_TRIG);
    busy_d       = (state_d != S_IDLE);
    meas_valid_d = done_hit || to_hit;
    timeout_d    = to_hit;
    meas_du_d    = meas_du_q;
    if (done_hit)    meas_du_d = bus.du;
    else if (to_hit) meas_du_d = 20'hFFFFF;
  end

  assign bus.trig       = trig_q;
  assign bus.busy       = busy_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.meas_du    = meas_du_q;

endmodule
